// File: rtl/vga_timing_gen_if.sv
// vga_if: pixel stream bundle carrying counts, sync/blank flags and colour
// for one pixel per clock from the timing generator to downstream draw stages.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );

    modport in (
        input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 (40 MHz) raster timing generator.
// Every field of the output bundle is registered from the same next-state
// values, so counts, sync/blank flags, colour and frame_start always describe
// one pixel in the same cycle.
// Optional feature macro: VGA_TIMING_BG_EN -- when defined, rgb carries a grey
// background (12'h888) in the visible area and black in blanking; when
// undefined, rgb is constantly black.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    vga_if.out   out,
    output logic frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST        = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLANK_START = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_BLANK_START = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_reg, hcount_next;
    logic [10:0] vcount_reg, vcount_next;
    logic        hsync_reg, hsync_next;
    logic        hblnk_reg, hblnk_next;
    logic        vsync_reg, vsync_next;
    logic        vblnk_reg, vblnk_next;
    logic [11:0] rgb_reg, rgb_next;
    logic        frame_start_reg, frame_start_next;

    // Next pixel position and all flags derived from it, so the registered
    // flags line up with the registered counts (no pipeline lag).
    always_comb begin
        hcount_next = hcount_reg + 11'd1;
        vcount_next = vcount_reg;
        // ">=" keeps the counters inside their legal range even from a corrupt state
        if (hcount_reg >= H_LAST) begin
            hcount_next = 11'd0;
            if (vcount_reg >= V_LAST) begin
                vcount_next = 11'd0;
            end else begin
                vcount_next = vcount_reg + 11'd1;
            end
        end

        hblnk_next = (hcount_next >= H_BLANK_START);
        hsync_next = (hcount_next >= H_SYNC_START) && (hcount_next < H_SYNC_END);
        vblnk_next = (vcount_next >= V_BLANK_START);
        vsync_next = (vcount_next >= V_SYNC_START) && (vcount_next < V_SYNC_END);

        frame_start_next = (hcount_next == 11'd0) && (vcount_next == 11'd0);

`ifdef VGA_TIMING_BG_EN
        rgb_next = (!hblnk_next && !vblnk_next) ? 12'h888 : 12'h000;
`else
        rgb_next = 12'h000;
`endif
    end

    // State update: reset wins over enable; a held enable freezes everything
    // except frame_start, which must never stay high for more than one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_reg      <= 11'd0;
            vcount_reg      <= 11'd0;
            hsync_reg       <= 1'b0;
            hblnk_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            vblnk_reg       <= 1'b0;
            rgb_reg         <= 12'h000;
            frame_start_reg <= 1'b0;
        end else if (en) begin
            hcount_reg      <= hcount_next;
            vcount_reg      <= vcount_next;
            hsync_reg       <= hsync_next;
            hblnk_reg       <= hblnk_next;
            vsync_reg       <= vsync_next;
            vblnk_reg       <= vblnk_next;
            rgb_reg         <= rgb_next;
            frame_start_reg <= frame_start_next;
        end else begin
            frame_start_reg <= 1'b0;
        end
    end

    assign out.hcount  = hcount_reg;
    assign out.vcount  = vcount_reg;
    assign out.hsync   = hsync_reg;
    assign out.hblnk   = hblnk_reg;
    assign out.vsync   = vsync_reg;
    assign out.vblnk   = vblnk_reg;
    assign out.rgb     = rgb_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. A full-size instance
// checks line-level timing; a reduced-geometry instance (32x16 total) shares
// the same rst/en stimulus so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

    // reduced geometry: H 20/3/5/4 -> 32, V 10/1/2/3 -> 16, 512 pixels per frame
    localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
    localparam int SVA = 10, SVF = 1, SVS = 2, SVB = 3;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;

    typedef logic [38:0] vec_t;
    typedef struct packed {
        vec_t exp_big;
        vec_t exp_sml;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic big_fs, sml_fs;

    vga_if big_vga ();
    vga_if sml_vga ();

    always #5 clk = ~clk;

    vga_timing_gen dut_big (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (big_vga),
        .frame_start (big_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
    ) dut_sml (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .out         (sml_vga),
        .frame_start (sml_fs)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    int   bh = 0, bv = 0, sh = 0, sv = 0;
    vec_t bexp = '0, sexp = '0;

    // observed statistics
    int big_hsync_cnt = 0, big_hblnk_cnt = 0;
    int sml_en_cycles = 0, sml_pulses = 0, sml_pulses_total = 0;

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t timing_vec(input int h, input int v,
                                        input int ha, input int hf, input int hs,
                                        input int va, input int vf, input int vs,
                                        input bit fs);
        bit hb, hy, vb, vy;
        logic [11:0] rgb;
        hb  = (h >= ha);
        hy  = (h >= ha + hf) && (h < ha + hf + hs);
        vb  = (v >= va);
        vy  = (v >= va + vf) && (v < va + vf + vs);
        rgb = 12'h000;
`ifdef VGA_TIMING_BG_EN
        if (!hb && !vb) rgb = 12'h888;
`endif
        return {11'(v), vy, vb, 11'(h), hy, hb, rgb, fs};
    endfunction

    task automatic model_step(inout int h, inout int v, inout vec_t e,
                              input int ha, input int hf, input int hs, input int hbp,
                              input int va, input int vf, input int vs, input int vbp,
                              input bit r, input bit en_v);
        int ht, vt;
        ht = ha + hf + hs + hbp;
        vt = va + vf + vs + vbp;
        if (r) begin
            h = 0;
            v = 0;
            e = '0;
        end else if (en_v) begin
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            e = timing_vec(h, v, ha, hf, hs, va, vf, vs, (h == 0) && (v == 0));
        end else begin
            e[0] = 1'b0;
        end
    endtask

    // One clock: drive inputs, push expectations, sample after the edge and compare.
    task automatic step(input bit r, input bit e_in);
        exp_t x;
        rst = r;
        en  = e_in;
        model_step(bh, bv, bexp, 800, 40, 128, 88, 600, 1, 4, 23, r, e_in);
        model_step(sh, sv, sexp, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, r, e_in);
        x.exp_big = bexp;
        x.exp_sml = sexp;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check_eq("big_pixel",
                 {big_vga.vcount, big_vga.vsync, big_vga.vblnk, big_vga.hcount,
                  big_vga.hsync, big_vga.hblnk, big_vga.rgb, big_fs}, x.exp_big);
        check_eq("sml_pixel",
                 {sml_vga.vcount, sml_vga.vsync, sml_vga.vblnk, sml_vga.hcount,
                  sml_vga.hsync, sml_vga.hblnk, sml_vga.rgb, sml_fs}, x.exp_sml);
        $display("cyc rst=%0b en=%0b big=(%0d,%0d) sml=(%0d,%0d) sml_fs=%0b",
                 r, e_in, big_vga.hcount, big_vga.vcount,
                 sml_vga.hcount, sml_vga.vcount, sml_fs);

        big_hsync_cnt += int'(big_vga.hsync);
        big_hblnk_cnt += int'(big_vga.hblnk);
        if (r) begin
            sml_en_cycles = 0;
            sml_pulses    = 0;
        end else begin
            if (e_in) sml_en_cycles++;
            if (sml_fs) begin
                sml_pulses_total++;
                if (sml_pulses > 0)
                    check_eq("sml_frame_period", vec_t'(sml_en_cycles), vec_t'(SHT * SVT));
                sml_pulses++;
                sml_en_cycles = 0;
            end
        end
    endtask

    initial begin
        bit reached;

        // reset, including with en high (reset overrides enable)
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
        check_eq("reset_fs", vec_t'(big_fs), vec_t'(0));

        // release: first enabled edge shows hcount=1, vcount=0
        big_hsync_cnt = 0;
        big_hblnk_cnt = 0;
        step(1'b0, 1'b1);
        check_eq("first_hcount", vec_t'(big_vga.hcount), vec_t'(1));
        check_eq("first_vcount", vec_t'(big_vga.vcount), vec_t'(0));
        check_eq("first_fs", vec_t'(big_fs), vec_t'(0));

        // rest of the first full line
        for (int i = 0; i < 1055; i++) step(1'b0, 1'b1);
        check_eq("wrap_hcount", vec_t'(big_vga.hcount), vec_t'(0));
        check_eq("wrap_vcount", vec_t'(big_vga.vcount), vec_t'(1));
        check_eq("line_hsync_cycles", vec_t'(big_hsync_cnt), vec_t'(128));
        check_eq("line_hblnk_cycles", vec_t'(big_hblnk_cnt), vec_t'(256));

        // keep running: several reduced frames, period checked on each pulse
        for (int i = 0; i < 1100; i++) step(1'b0, 1'b1);
        check_eq("sml_pulses_seen", vec_t'(sml_pulses_total >= 3), vec_t'(1));

        // freeze at the last pixel of the reduced frame
        reached = 1'b0;
        for (int i = 0; i < 2 * SHT * SVT && !reached; i++) begin
            step(1'b0, 1'b1);
            reached = (sh == SHT - 1) && (sv == SVT - 1);
        end
        check_eq("reach_frame_end", vec_t'(reached), vec_t'(1));
        check_eq("end_hcount", vec_t'(sml_vga.hcount), vec_t'(SHT - 1));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check_eq("frozen_fs", vec_t'(sml_fs), vec_t'(0));
        end
        step(1'b0, 1'b1);
        check_eq("resume_pos", vec_t'({sml_vga.hcount, sml_vga.vcount}), vec_t'(0));
        check_eq("resume_fs", vec_t'(sml_fs), vec_t'(1));
        step(1'b0, 1'b1);
        check_eq("resume_fs_drop", vec_t'(sml_fs), vec_t'(0));

        // mid-frame reset on the reduced instance
        reached = 1'b0;
        for (int i = 0; i < 2 * SHT * SVT && !reached; i++) begin
            step(1'b0, 1'b1);
            reached = (sh == 10) && (sv == 5);
        end
        check_eq("reach_mid_frame", vec_t'(reached), vec_t'(1));
        step(1'b1, 1'b1);
        check_eq("midrst_sml_all", {sml_vga.vcount, sml_vga.vsync, sml_vga.vblnk,
                 sml_vga.hcount, sml_vga.hsync, sml_vga.hblnk, sml_vga.rgb, sml_fs}, '0);
        step(1'b0, 1'b1);
        check_eq("post_rst_hcount", vec_t'(sml_vga.hcount), vec_t'(1));
        check_eq("post_rst_vcount", vec_t'(sml_vga.vcount), vec_t'(0));

        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 800: visible pixels per line.
REQ-002 Parameter H_FP, 40 / H_SYNC, 128 / H_BP, 88: horizontal front porch, sync width and back porch in pixels; H_TOTAL = 1056.
REQ-003 Parameter V_ACTIVE, 600: visible lines per frame.
REQ-004 Parameter V_FP, 1 / V_SYNC, 4 / V_BP, 23: vertical front porch, sync width and back porch in lines; V_TOTAL = 628.
REQ-005 Port clk, input, 1: pixel clock (40 MHz); one clock, all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port en, input, 1: count enable; low freezes all outputs.
REQ-008 Port out, vga_if.out: vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]; source of the stream consumed by downstream draw stages.
REQ-009 Port frame_start, output, 1: one-cycle pulse marking pixel (0,0).

Function
REQ-010 All outputs SHALL be registered; every field of out SHALL describe the same pixel in the same cycle.
REQ-011 out.hcount SHALL increment by 1 on each clk with en=1, wrapping from H_TOTAL-1 to 0.
REQ-012 out.vcount SHALL increment only on the hcount wrap, wrapping from V_TOTAL-1 to 0 together with hcount.
REQ-013 out.hblnk SHALL be 1 exactly when hcount >= H_ACTIVE (800..1055).
REQ-014 out.hsync SHALL be 1, positive polarity, exactly when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967).
REQ-015 out.vblnk SHALL be 1 exactly when vcount >= V_ACTIVE (600..627), for the whole line including its hblnk region.
REQ-016 out.vsync SHALL be 1, positive polarity, exactly when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604).
REQ-017 Flags SHALL be computed from the next counter values so they change in the same cycle as the counts; zero lag.
REQ-018 frame_start SHALL be 1 for exactly one cycle, when the counters advance to (hcount=0, vcount=0); it SHALL not assert during or on leaving reset.
REQ-019 With en=0, counters, flags, rgb and frame_start SHALL hold their values, except that frame_start SHALL drop to 0.
REQ-020 Counter arithmetic SHALL be 11-bit unsigned, with no values outside 0..H_TOTAL-1 or 0..V_TOTAL-1 ever reaching out.

Reset
REQ-021 While rst=1: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, rgb=12'h000, frame_start=0; rst overrides en.
REQ-022 On the first clk edge with rst=0 and en=1, out SHALL show hcount=1, vcount=0.
REQ-023 rst asserted mid-line or mid-frame SHALL force the reset values on the next clk edge, with no partial-line completion.

Configuration
REQ-024 Macro VGA_TIMING_BG_EN defined: out.rgb SHALL be 12'h8_8_8 when hblnk=0 and vblnk=0, and 12'h0_0_0 when either is 1, registered with the counts.
REQ-025 Macro VGA_TIMING_BG_EN undefined: out.rgb SHALL be 12'h0_0_0 constantly; timing outputs are identical in both builds.

Verification
REQ-026 Release rst, en=1, run 1056 clocks -> hcount runs 1..1055 then 0, vcount steps 0->1 on that wrap, hblnk rises at hcount=800.
REQ-027 Run one full line -> hsync high for exactly 128 cycles, hcount 840..967; hblnk high for 256 cycles.
REQ-028 Run 628*1056 clocks -> vsync high for lines 601..604 only, vblnk for lines 600..627, frame_start pulses exactly once at (0,0), then again after 663168 cycles.
REQ-029 Drop en for 10 cycles at hcount=1055, vcount=627 -> all outputs frozen with frame_start=0; on en=1 counters go to (0,0) and frame_start pulses once.
REQ-030 Assert rst at hcount=500, vcount=300 for one cycle -> next cycle all outputs at reset values; after release hcount=1, vcount=0.
REQ-031 Build with VGA_TIMING_BG_EN -> rgb=12'h888 at (0,0) and at (799,599), 12'h000 at (800,0) and at (0,600); build without it -> rgb=12'h000 everywhere.
